// File: rtl/key_dispenser.sv
// Key dispenser for the RC4 key-search datapath. It hands out 24-bit keys
// round-robin to the requesting cores and latches the first match or keyspace exhaustion.
module key_dispenser #(
    parameter int          NUM_CORES = 4,
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] req,
    input  logic [NUM_CORES-1:0] miss,
    input  logic [NUM_CORES-1:0] found,
    output logic [NUM_CORES-1:0] gnt,
    output logic [23:0]          key_out,
    output logic                 busy,
    output logic                 match_found,
    output logic                 all_keys_checked,
    output logic [23:0]          winning_key,
    output logic [2:0]           winning_core
);

    typedef enum logic [1:0] {IDLE, DISPENSE, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [24:0]          next_key;
    logic [NUM_CORES-1:0] outstanding;
    logic [2:0]           rr_ptr;
    logic [23:0]          held_key [NUM_CORES];

    logic [NUM_CORES-1:0] eligible, found_ok, gnt_mask;
    logic [7:0]           elig8;
    logic [2:0]           cand, grant_idx, found_idx;
    logic [23:0]          found_key;
    logic                 grant_ok, found_hit;
    logic                 do_start, do_grant, do_match, do_exhaust;

    assign eligible = req & ~outstanding;
    assign elig8    = 8'(eligible);
    assign found_ok = found & outstanding & {NUM_CORES{(state == DISPENSE) || (state == DRAIN)}};
    assign busy     = (state == DISPENSE) || (state == DRAIN);

    // Round-robin search starting at rr_ptr.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = 3'd0;
        cand      = 3'd0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = 3'((int'(rr_ptr) + k) % NUM_CORES);
            if (!grant_ok && elig8[cand]) begin
                grant_ok  = 1'b1;
                grant_idx = cand;
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            gnt_mask[i] = grant_ok && (grant_idx == 3'(i));
        end
    end

    // Descending scan so the lowest-indexed reporting core wins.
    always_comb begin
        found_hit = 1'b0;
        found_idx = 3'd0;
        found_key = 24'd0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (found_ok[i]) begin
                found_hit = 1'b1;
                found_idx = 3'(i);
                found_key = held_key[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        do_grant   = 1'b0;
        do_match   = 1'b0;
        do_exhaust = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = DISPENSE;
                end
            end
            DISPENSE: begin
                if (found_hit) begin
                    do_match  = 1'b1;
                    state_nxt = DONE;
                end else if (grant_ok) begin
                    do_grant = 1'b1;
                    if (next_key == {1'b0, KEY_MAX}) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (found_hit) begin
                    do_match  = 1'b1;
                    state_nxt = DONE;
                end else if (outstanding == '0) begin
                    do_exhaust = 1'b1;
                    state_nxt  = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt              <= '0;
            key_out          <= 24'd0;
            match_found      <= 1'b0;
            all_keys_checked <= 1'b0;
            winning_key      <= 24'd0;
            winning_core     <= 3'd0;
            next_key         <= {1'b0, KEY_START};
            outstanding      <= '0;
            rr_ptr           <= 3'd0;
            for (int i = 0; i < NUM_CORES; i++) begin
                held_key[i] <= 24'd0;
            end
        end else begin
            gnt     <= '0;
            key_out <= 24'd0;
            if (do_start) begin
                next_key         <= {1'b0, KEY_START};
                outstanding      <= '0;
                rr_ptr           <= 3'd0;
                match_found      <= 1'b0;
                all_keys_checked <= 1'b0;
            end else begin
                // Grant only targets cores with a clear bit, so set and clear never collide.
                outstanding <= (outstanding & ~miss) | gnt_mask & {NUM_CORES{do_grant}};
                if (do_grant) begin
                    gnt      <= gnt_mask;
                    key_out  <= next_key[23:0];
                    next_key <= next_key + 25'd1;
                    rr_ptr   <= (grant_idx == 3'(NUM_CORES - 1)) ? 3'd0 : grant_idx + 3'd1;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (gnt_mask[i]) begin
                            held_key[i] <= next_key[23:0];
                        end
                    end
                end
                if (do_match) begin
                    match_found  <= 1'b1;
                    winning_key  <= found_key;
                    winning_core <= found_idx;
                end
                if (do_exhaust) begin
                    all_keys_checked <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/key_dispenser.md
# key_dispenser

Keyspace responder for the RC4 key-search datapath. It answers key requests from up to NUM_CORES decrypt/check cores. Requests are arbitrated round-robin, and each winning core receives the next untried 24-bit secret key. The block records the key held by each core, latches the first reported match, and flags keyspace exhaustion; the top level drives LEDR and the HEX decoders from these results.

## Interface
- NUM_CORES, 4: number of requesting cores, 1..8.
- KEY_START, 24'h000000: first key issued after start.
- KEY_MAX, 24'hFFFFFF: last key issued, inclusive, with KEY_MAX >= KEY_START.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a search from IDLE.
- req  in  NUM_CORES  per-core key request, level, held until granted.
- miss  in  NUM_CORES  per-core pulse: held key checked, no match.
- found  in  NUM_CORES  per-core pulse: held key decrypts to valid text.
- gnt  out  NUM_CORES  one-hot grant, one cycle wide.
- key_out  out  24  key for the granted core, valid only while gnt != 0.
- busy  out  1  state is DISPENSE or DRAIN.
- match_found  out  1  sticky; a match has been latched.
- all_keys_checked  out  1  sticky; keyspace exhausted with no match.
- winning_key  out  24  key reported by the first matching core.
- winning_core  out  3  index of that core.

## Operation
- States:
  - IDLE: waits for start.
  - DISPENSE: grants keys.
  - DRAIN: keyspace exhausted; waits on outstanding cores.
  - DONE: holds results.
- Reset values of all outputs and internal registers:
  - gnt=0, key_out=0, busy=0, match_found=0, all_keys_checked=0, winning_key=0, winning_core=0.
  - next_key=KEY_START, outstanding=0, rr_ptr=0, state=IDLE.
- IDLE -> DISPENSE on start.
  - next_key loads KEY_START.
  - Sticky flags, outstanding and rr_ptr clear.
- Eligibility in DISPENSE:
  - A core is eligible when req[i]=1 and outstanding[i]=0.
  - At most one grant per cycle.
  - Search starts at rr_ptr and wraps modulo NUM_CORES.
  - rr_ptr becomes the granted index + 1, wrapping modulo NUM_CORES.
- On a grant to core i:
  - gnt[i]=1 and key_out=next_key.
  - held_key[i] takes next_key and outstanding[i] sets.
  - next_key increments.
- next_key is 25 bits wide, so KEY_MAX=24'hFFFFFF does not wrap to 0. When the issued key equals KEY_MAX, the state moves to DRAIN.
- miss[i] with outstanding[i]=1 clears outstanding[i].
- miss or found from a core whose outstanding bit is 0 is ignored.
- found[i] with outstanding[i]=1, in DISPENSE or DRAIN:
  - match_found, winning_key and winning_core are set.
  - The state moves to DONE and no further grants issue.
- Simultaneous valid found pulses: the lowest index wins.
- found has priority over a same-cycle grant; that grant is suppressed.
- DRAIN -> DONE when outstanding==0 with no match. all_keys_checked sets.
- DONE: holds until the next start, which behaves exactly as from IDLE.
- start outside IDLE/DONE is ignored.
- reset_n low at any time, including mid-search, returns every register to its reset value immediately.

## Timing
- req sampled at edge N -> gnt and key_out registered, high for cycle N+1 only.
- A core that still holds req during N+1 is not regranted, because its outstanding bit is set.
- found or miss sampled at edge N -> flags and outstanding updated at N+1.
- busy deasserts in the same cycle that match_found or all_keys_checked first reads 1.
- start -> first grant possible 2 cycles later (IDLE->DISPENSE, then arbitration).
- Sustained throughput is one key per cycle when at least one core is eligible.

## Test plan
- Round-robin and exhaustion, NUM_CORES=4, KEY_START=0, KEY_MAX=5:
  - Stimulus: all req held high, each core pulses miss 3 cycles after its grant.
  - Grants go to cores 0,1,2,3,0,1 with keys 0..5.
  - No seventh grant; all_keys_checked=1 after the last miss; match_found=0.
- Match and grant suppression:
  - Stimulus: core 2 pulses found while holding key 24'h0000A7.
  - winning_key=24'h0000A7, winning_core=2, match_found=1.
  - A grant pending in the same cycle is suppressed.
- Simultaneous found on cores 1 and 3 -> winning_core=1.
- Spurious pulse: found[0] while outstanding[0]=0 -> ignored, search continues.
- Top-of-space wrap: KEY_START=KEY_MAX=24'hFFFFFF, single request -> key_out=24'hFFFFFF, then DRAIN; key 0 is never issued.
- Mid-search reset: reset_n low mid-DISPENSE -> all outputs 0 and state IDLE; a following start reissues KEY_START.
